// File: rtl/pwm_pkg.sv
// Shared types and width helpers for the PWM capture block.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_state_t;

    // Measurement counters carry one extra bit so a full 2^n-cycle period fits.
    function automatic int cnt_width(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer plus a delay flop for edge detection on an async PWM line.
module pwm_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic pwmIn,
    output logic rise,
    output logic fall
);

    logic meta;
    logic pwmSync;
    logic pwmPrev;

    // Resetting to 1 keeps a line that is already high from looking like a rise.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta    <= 1'b1;
            pwmSync <= 1'b1;
            pwmPrev <= 1'b1;
        end else begin
            meta    <= pwmIn;
            pwmSync <= meta;
            pwmPrev <= pwmSync;
        end
    end

    assign rise = pwmSync & ~pwmPrev;
    assign fall = ~pwmSync & pwmPrev;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of a PWM input; one dataValid strobe per full period.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int N = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pwmIn,
    output logic [N:0]       highTime,
    output logic [N:0]       periodTime,
    output logic             dataValid,
    output logic             timeout,
    output logic [1:0]       fsm_state
);

    localparam int             CW      = cnt_width(N);
    localparam logic [CW-1:0]  CNT_MAX = '1;

    logic          rise;
    logic          fall;
    logic [CW-1:0] cnt;
    logic [CW-1:0] highLatch;
    pwm_state_t    state;
    pwm_state_t    next_state;
    logic          capture_high;
    logic          report;
    logic          set_timeout;

    pwm_edge_sync u_sync (
        .clock (clock),
        .reset (reset),
        .pwmIn (pwmIn),
        .rise  (rise),
        .fall  (fall)
    );

    // Valid/ready does not apply here: dataValid is a one-cycle strobe with no
    // back-pressure, and highTime/periodTime hold until the next strobe.
    always_comb begin
        next_state   = state;
        capture_high = 1'b0;
        report       = 1'b0;
        set_timeout  = 1'b0;
        if (cnt == CNT_MAX && !rise && !fall) begin
            set_timeout = 1'b1;
            next_state  = IDLE;
        end else begin
            case (state)
                IDLE: if (rise) next_state = HIGH;
                HIGH: if (fall) begin
                    capture_high = 1'b1;
                    next_state   = LOW;
                end
                LOW: if (rise) begin
                    report     = 1'b1;
                    next_state = HIGH;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            highLatch  <= '0;
            highTime   <= '0;
            periodTime <= '0;
            dataValid  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state     <= next_state;
            dataValid <= report;
            if (rise)
                cnt <= CW'(1);
            else if (cnt != CNT_MAX)
                cnt <= cnt + CW'(1);
            if (capture_high)
                highLatch <= cnt;
            if (report) begin
                periodTime <= cnt;
                highTime   <= highLatch;
                timeout    <= 1'b0;
            end
            if (set_timeout)
                timeout <= 1'b1;
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: segment table plus hand-written reset corner cases.
module tb_pwm_capture;

    localparam int N = 8;
    localparam int W = 2 * (N + 1);

    logic         clock;
    logic         reset;
    logic         pwmIn;
    logic [N:0]   highTime;
    logic [N:0]   periodTime;
    logic         dataValid;
    logic         timeout;
    logic [1:0]   fsm_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    // Input-side reference: counts driven high/low cycles between rises.
    logic m_last;
    logic m_armed;
    int   m_hc;
    int   m_lc;
    logic mon_en;
    logic done;

    pwm_capture #(.N(N)) dut (
        .clock      (clock),
        .reset      (reset),
        .pwmIn      (pwmIn),
        .highTime   (highTime),
        .periodTime (periodTime),
        .dataValid  (dataValid),
        .timeout    (timeout),
        .fsm_state  (fsm_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input logic v);
        logic [W-1:0] e;
        @(negedge clock);
        reset = 1'b0;
        pwmIn = v;
        if (v && !m_last) begin
            if (m_armed) begin
                e = {(N+1)'(m_hc), (N+1)'(m_hc + m_lc)};
                exp_q.push_back(e);
            end
            m_armed = 1'b1;
            m_hc = 1;
            m_lc = 0;
        end else if (m_armed) begin
            if (v) m_hc++;
            else   m_lc++;
            if (m_hc + m_lc > 511) m_armed = 1'b0;
        end
        m_last = v;
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) drive(v);
    endtask

    task automatic periods(input int h, input int l, input int reps);
        for (int r = 0; r < reps; r++) begin
            hold(1'b1, h);
            hold(1'b0, l);
        end
    endtask

    task automatic reset_cycle(input logic v);
        @(negedge clock);
        reset   = 1'b1;
        pwmIn   = v;
        m_last  = 1'b1;
        m_armed = 1'b0;
        m_hc    = 0;
        m_lc    = 0;
        @(posedge clock);
        #1;
        check("reset_dataValid", int'(dataValid), 0);
        check("reset_timeout", int'(timeout), 0);
        check("reset_highTime", int'(highTime), 0);
        check("reset_periodTime", int'(periodTime), 0);
    endtask

    task automatic check_outputs(input string tag, input logic to, input int ht, input int pt);
        @(posedge clock);
        #1;
        check({tag, "_timeout"}, int'(timeout), int'(to));
        check({tag, "_highTime"}, int'(highTime), ht);
        check({tag, "_periodTime"}, int'(periodTime), pt);
    endtask

    // Scoreboard monitor: every strobe must match the next expected measurement.
    initial begin : monitor
        logic         prev_dv;
        logic [W-1:0] e;
        prev_dv = 1'b0;
        wait (mon_en === 1'b1);
        while (!done) begin
            @(posedge clock);
            #1;
            if (dataValid === 1'b1) begin
                check("dv_not_consecutive", int'(prev_dv), 0);
                check("dv_clears_timeout", int'(timeout), 0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_valid: got %0d/%0d, expected no strobe",
                             highTime, periodTime);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_highTime", int'(highTime), int'(e[W-1:N+1]));
                    check("sb_periodTime", int'(periodTime), int'(e[N:0]));
                end
            end
            prev_dv = (dataValid === 1'b1);
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int         kind;   // 0 reset, 1 hold low, 2 hold high, 3 periodic h/l
        int         h;
        int         l;
        int         reps;
        logic       exp_to;
        int         exp_ht;
        int         exp_pt;
    } row_t;

    row_t rows[12];

    initial begin : main
        reset   = 1'b1;
        pwmIn   = 1'b0;
        m_last  = 1'b1;
        m_armed = 1'b0;
        m_hc    = 0;
        m_lc    = 0;
        mon_en  = 1'b0;
        done    = 1'b0;

        rows[0]  = '{0, 0,   0,   0,  1'b0, 0,   0};
        rows[1]  = '{1, 400, 0,   0,  1'b0, 0,   0};
        rows[2]  = '{1, 200, 0,   0,  1'b1, 0,   0};
        rows[3]  = '{0, 0,   0,   0,  1'b0, 0,   0};
        rows[4]  = '{2, 400, 0,   0,  1'b0, 0,   0};
        rows[5]  = '{2, 200, 0,   0,  1'b1, 0,   0};
        rows[6]  = '{0, 0,   0,   0,  1'b0, 0,   0};
        rows[7]  = '{3, 10,  246, 4,  1'b0, 10,  256};
        rows[8]  = '{3, 100, 156, 3,  1'b0, 100, 256};
        rows[9]  = '{3, 1,   1,   20, 1'b0, 1,   2};
        rows[10] = '{1, 700, 0,   0,  1'b1, 1,   2};
        rows[11] = '{3, 10,  246, 3,  1'b0, 10,  256};

        repeat (3) @(posedge clock);

        for (int i = 0; i < 12; i++) begin
            case (rows[i].kind)
                0: begin
                    reset_cycle(pwmIn);
                    mon_en = 1'b1;
                end
                1: hold(1'b0, rows[i].h);
                2: hold(1'b1, rows[i].h);
                default: periods(rows[i].h, rows[i].l, rows[i].reps);
            endcase
            check_outputs($sformatf("row%0d", i), rows[i].exp_to, rows[i].exp_ht, rows[i].exp_pt);
        end

        // Reset in the middle of a high phase drops the measurement in progress.
        periods(10, 246, 3);
        hold(1'b1, 5);
        reset_cycle(1'b1);
        hold(1'b1, 5);
        hold(1'b0, 246);
        check_outputs("midreset_quiet", 1'b0, 0, 0);
        periods(10, 246, 3);
        check_outputs("midreset_resume", 1'b0, 10, 256);

        // Line held high through reset release must not count as a rise.
        hold(1'b0, 20);
        reset_cycle(1'b1);
        reset_cycle(1'b1);
        reset_cycle(1'b1);
        hold(1'b1, 20);
        hold(1'b0, 30);
        check_outputs("highrel_quiet", 1'b0, 0, 0);
        periods(50, 206, 3);
        hold(1'b0, 10);
        check_outputs("highrel_resume", 1'b0, 50, 256);

        done = 1'b1;
        repeat (3) @(posedge clock);
        check("sb_queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform and reports its high time and period in clock cycles. It is the receive-side counterpart of the `pwm` generator. It is intended for loop-back checking of generated PWM and for decoding external PWM inputs such as fan tachometers and servo feedback. Each completed rising-to-rising cycle yields one measurement with a one-cycle valid strobe.

## Interface
- `N`, 8, generator counter width. Measurement counters are N+1 bits, so a full 2^N-cycle generator period is representable.
- `reset`  in  1  synchronous, active-high reset.
- `clock`  in  1  single clock; all logic on the rising edge.
- `pwmIn`  in  1  PWM input, asynchronous to `clock`.
- `highTime`  out  N+1  cycles `pwmIn` was high in the last complete period.
- `periodTime`  out  N+1  cycles from one rising edge to the next.
- `dataValid`  out  1  one-cycle pulse when `highTime`/`periodTime` update.
- `timeout`  out  1  level flag: no edge within 2^(N+1)-1 cycles.

## Operation
- **Input synchronizer:** `pwmIn` passes through 2 flops to produce `pwmSync`, then 1 more flop to produce `pwmPrev`.
  - All three flops reset to 1, so a line that is high at reset release produces no false rise.
- **Edge detect:**
  - `rise` = `pwmSync & ~pwmPrev`.
  - `fall` = `~pwmSync & pwmPrev`.
- **Counter `cnt` (N+1 bits):**
  - Reset to 0.
  - On `rise`: load 1.
  - Otherwise: increment, saturating at MAX = 2^(N+1)-1.
- **FSM states:** IDLE, HIGH, LOW. Reset state is IDLE.
  - IDLE, on `rise`: go to HIGH. `fall` is ignored. No output update.
  - HIGH, on `fall`: `highLatch <= cnt`, go to LOW.
  - LOW, on `rise`: `periodTime <= cnt`, `highTime <= highLatch`, pulse `dataValid`, clear `timeout`, go to HIGH.
  - Any state, when `cnt == MAX` and there is no edge this cycle: set `timeout`, go to IDLE. `highTime`/`periodTime` hold their last values.
- The first measurement after reset or timeout needs two rises. The partial period before the first rise is always discarded.
- **Duty-cycle limits:** 0% and 100% duty (constant level) are reported only via `timeout`. No `dataValid` is produced.
- **Reset mid-operation:** all state, the counter, `highLatch` and the outputs return to reset values on the next edge. Any in-progress measurement is lost.
- **Reset values:** `highTime`=0, `periodTime`=0, `dataValid`=0, `timeout`=0.

## Timing
- Edge-to-strobe latency:
  - A `pwmIn` rising edge sampled at clock edge e0 makes `pwmSync` high after e1.
  - `rise` is then combinational in the following cycle.
  - `dataValid`, `highTime` and `periodTime` are registered at e2, i.e. visible 2 cycles after the sampling edge.
- The synchronizer delays both edges equally, so measured values are exact for a clean input:
  - high for H cycles and low for L cycles gives `highTime`=H, `periodTime`=H+L.
  - Minimum measurable pulse is H=1, L=1.
- `dataValid` is high for exactly one cycle per period. It is never asserted on two consecutive cycles unless `periodTime`=1, which cannot occur because the minimum period is 2.
- `timeout` rises on the cycle after `cnt` reaches MAX without an edge. It stays high until the next `dataValid` or reset.

## Structure
- Package `pwm_pkg` holds:
  - the FSM state type (IDLE/HIGH/LOW);
  - a width function or constant giving N+1 and MAX.
- Sub-module `pwm_edge_sync` contains the 2-flop synchronizer, the `pwmPrev` flop (reset to 1) and the `rise`/`fall` outputs, parameterless.
- Top-level `pwm_capture` holds the counter, FSM and output registers.

## Test plan
- **Nominal duty:** `pwmIn` high 10, low 246, repeated. Required: after the second rise, `dataValid` pulses every 256 cycles with `highTime`=10, `periodTime`=256; `timeout`=0.
- **Duty change:** switch the same stream to high 100, low 156. Required: the first full new period reports 100/256; no mixed value is reported.
- **Constant levels:**
  - `pwmIn` held 0 for 600 cycles after reset. Required: no `dataValid`; `timeout`=1 from cycle ≈512 onward; `highTime`/`periodTime` stay 0.
  - Repeat with `pwmIn` held 1. Required: identical response.
- **Minimum pulse:** high 1, low 1. Required: `dataValid` every 2 cycles, `highTime`=1, `periodTime`=2. Then hold the input low until timeout, and resume 10/246. Required: `timeout` clears on the first new `dataValid`, which reports 10/256.
- **Reset mid-high:** assert `reset` for 1 cycle mid-high during the 10/246 stream. Required: all outputs 0 on the next cycle; no `dataValid` until two further rises; the first report is 10/256.
- **High through reset release:** `pwmIn`=1 through reset release, then fall, then a 50/206 stream. Required: no spurious rise; the first report is 50/256.
